// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencer for an external 4-mode universal shift register.
// It takes a parallel word over a valid/ready command port and loads it into
// the register. It then shifts the word out serially while capturing
// serial_in, and returns the captured word on a valid/ready response port.
module shift_seq_ctrl #(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_msb_first,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   input  logic             serial_in,
   output logic             serial_out,
   output logic             busy,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [1:0]       sr_s,
   output logic [WIDTH-1:0] sr_in,
   output logic             sr_serial_in,
   input  logic [WIDTH-1:0] sr_q
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic             msb_first_q;
   logic [WIDTH-1:0] data_q;
   logic [CW-1:0]    div_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             strobe;

   assign strobe = (state == SHIFT) && (div_cnt == DIV_LAST);

   // Sequencer state, bit-period divider, bit counter and captured command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         msb_first_q <= 1'b0;
         data_q      <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  msb_first_q <= cmd_msb_first;
                  data_q      <= cmd_data;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
               end else if (strobe) begin
                  div_cnt <= '0;
                  bit_cnt <= bit_cnt + BW'(1);
                  if (bit_cnt == BIT_LAST) begin
                     state <= DONE;
                  end
               end else begin
                  div_cnt <= div_cnt + CW'(1);
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shift register mode select; abort suppresses the load or shift on its
   // own edge, so it is the one control input gated in directly.
   always_comb begin
      sr_s = 2'b00;
      if (!abort) begin
         if (state == LOAD) begin
            sr_s = 2'b11;
         end else if (strobe) begin
            sr_s = msb_first_q ? 2'b10 : 2'b01;
         end
      end
   end

   // Handshake, status and serial datapath decode
   always_comb begin
      cmd_ready    = (state == IDLE);
      busy         = (state != IDLE);
      rsp_valid    = (state == DONE);
      rsp_data     = (state == DONE) ? sr_q : '0;
      sr_in        = data_q;
      sr_serial_in = serial_in;
      serial_out   = 1'b0;
      if (state == SHIFT) begin
         serial_out = msb_first_q ? sr_q[WIDTH-1] : sr_q[0];
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl. Two instances (CLKS_PER_BIT 2 and 1)
// each drive a behavioural universal shift register; transfers are checked
// cycle by cycle against timing and data derived from arithmetic.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_msb_first, abort, rsp_ready, si_val, loop_en;
   logic [3:0] cmd_data;
   int         sel;
   int         n_checks = 0;
   int         n_fail   = 0;

   logic       cmd_ready_a, serial_out_a, busy_a, rsp_valid_a, sr_serial_in_a, serial_in_a;
   logic [3:0] rsp_data_a, sr_in_a, sr_q_a;
   logic [1:0] sr_s_a;
   logic       cmd_ready_b, serial_out_b, busy_b, rsp_valid_b, sr_serial_in_b, serial_in_b;
   logic [3:0] rsp_data_b, sr_in_b, sr_q_b;
   logic [1:0] sr_s_b;
   logic       cmd_valid_a, cmd_valid_b;

   always #5 clk = ~clk;

   assign cmd_valid_a = cmd_valid && (sel == 0);
   assign cmd_valid_b = cmd_valid && (sel != 0);
   assign serial_in_a = loop_en ? serial_out_a : si_val;
   assign serial_in_b = loop_en ? serial_out_b : si_val;

   shift_seq_ctrl #(.WIDTH(4), .CLKS_PER_BIT(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
      .cmd_msb_first(cmd_msb_first), .cmd_data(cmd_data), .abort(abort),
      .serial_in(serial_in_a), .serial_out(serial_out_a), .busy(busy_a),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
      .sr_s(sr_s_a), .sr_in(sr_in_a), .sr_serial_in(sr_serial_in_a), .sr_q(sr_q_a)
   );

   shift_seq_ctrl #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
      .cmd_msb_first(cmd_msb_first), .cmd_data(cmd_data), .abort(abort),
      .serial_in(serial_in_b), .serial_out(serial_out_b), .busy(busy_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
      .sr_s(sr_s_b), .sr_in(sr_in_b), .sr_serial_in(sr_serial_in_b), .sr_q(sr_q_b)
   );

   // External universal shift registers: 00 hold, 01 right, 10 left, 11 load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q_a <= '0;
      else case (sr_s_a)
         2'b01:   sr_q_a <= {sr_serial_in_a, sr_q_a[3:1]};
         2'b10:   sr_q_a <= {sr_q_a[2:0], sr_serial_in_a};
         2'b11:   sr_q_a <= sr_in_a;
         default: sr_q_a <= sr_q_a;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q_b <= '0;
      else case (sr_s_b)
         2'b01:   sr_q_b <= {sr_serial_in_b, sr_q_b[3:1]};
         2'b10:   sr_q_b <= {sr_q_b[2:0], sr_serial_in_b};
         2'b11:   sr_q_b <= sr_in_b;
         default: sr_q_b <= sr_q_b;
      endcase
   end

   // Observation of the instance under test
   logic       o_ready, o_sout, o_busy, o_rvalid;
   logic [3:0] o_rdata, o_sr_in;
   logic [1:0] o_sr_s;
   assign o_ready  = (sel != 0) ? cmd_ready_b  : cmd_ready_a;
   assign o_sout   = (sel != 0) ? serial_out_b : serial_out_a;
   assign o_busy   = (sel != 0) ? busy_b       : busy_a;
   assign o_rvalid = (sel != 0) ? rsp_valid_b  : rsp_valid_a;
   assign o_rdata  = (sel != 0) ? rsp_data_b   : rsp_data_a;
   assign o_sr_in  = (sel != 0) ? sr_in_b      : sr_in_a;
   assign o_sr_s   = (sel != 0) ? sr_s_b       : sr_s_a;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      rsp_ready = 1'b0;
   endtask

   // One transfer, entered and left just after a rising edge with the DUT idle.
   // mode: 0 loopback, 1 serial_in=0, 2 serial_in=1, 3 random bits.
   // abort_at: -1 none, 0 abort alongside the command, else cycle of abort.
   task automatic xfer(input int s, input logic [3:0] d, input logic msb,
                       input int mode, input int abort_at, input int hold);
      int cpb, done_cyc, j, k, c;
      logic [3:0] tx, inb, exp_rx;
      logic [1:0] exp_s;
      bit aborted;
      cpb      = (s != 0) ? 1 : 2;
      done_cyc = 2 + 4 * cpb;
      for (int i = 0; i < 4; i++) tx[i] = msb ? d[3-i] : d[i];
      for (int i = 0; i < 4; i++) begin
         case (mode)
            1:       inb[i] = 1'b0;
            2:       inb[i] = 1'b1;
            3:       inb[i] = 1'($urandom);
            default: inb[i] = tx[i];
         endcase
      end
      for (int i = 0; i < 4; i++) begin
         if (msb) exp_rx[3-i] = inb[i];
         else     exp_rx[i]   = inb[i];
      end
      sel           = s;
      loop_en       = (mode == 0);
      cmd_valid     = 1'b1;
      cmd_data      = d;
      cmd_msb_first = msb;
      abort         = (abort_at == 0);
      rsp_ready     = 1'($urandom);
      si_val        = 1'($urandom);
      @(negedge clk);
      check("idle_ready", 32'(o_ready), 32'd1);
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_rvalid", 32'(o_rvalid), 32'd0);
      check("idle_sr_s", 32'(o_sr_s), 32'd0);
      check("idle_sout", 32'(o_sout), 32'd0);
      @(posedge clk); #1;
      aborted = 0;
      c = 1;
      while (c < done_cyc && !aborted) begin
         cmd_valid     = 1'($urandom);
         cmd_data      = 4'($urandom);
         cmd_msb_first = 1'($urandom);
         rsp_ready     = 1'($urandom);
         abort         = (c == abort_at);
         k = 0;
         if (c == 1) begin
            exp_s  = 2'b11;
            si_val = 1'($urandom);
         end else begin
            j      = c - 2;
            k      = j / cpb;
            si_val = inb[k];
            exp_s  = ((j % cpb) == cpb - 1) ? (msb ? 2'b10 : 2'b01) : 2'b00;
         end
         if (c == abort_at) exp_s = 2'b00;
         @(negedge clk);
         check("xfer_sr_s", 32'(o_sr_s), 32'(exp_s));
         check("xfer_busy", 32'(o_busy), 32'd1);
         check("xfer_ready", 32'(o_ready), 32'd0);
         check("xfer_rvalid", 32'(o_rvalid), 32'd0);
         check("xfer_sout", 32'(o_sout), (c == 1) ? 32'd0 : 32'(tx[k]));
         if (c == 1) check("load_sr_in", 32'(o_sr_in), 32'(d));
         @(posedge clk); #1;
         if (c == abort_at) aborted = 1;
         c++;
      end
      if (aborted) begin
         idle_inputs();
         return;
      end
      for (int h = 0; h <= hold; h++) begin
         cmd_valid = 1'b1;
         cmd_data  = 4'($urandom);
         abort     = 1'($urandom);
         rsp_ready = (h == hold);
         @(negedge clk);
         check("done_rvalid", 32'(o_rvalid), 32'd1);
         check("done_rdata", 32'(o_rdata), 32'(exp_rx));
         check("done_ready", 32'(o_ready), 32'd0);
         check("done_busy", 32'(o_busy), 32'd1);
         check("done_sr_s", 32'(o_sr_s), 32'd0);
         check("done_sout", 32'(o_sout), 32'd0);
         @(posedge clk); #1;
      end
      idle_inputs();
      @(negedge clk);
      check("post_busy", 32'(o_busy), 32'd0);
      check("post_rvalid", 32'(o_rvalid), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(cmd_ready_a), 32'd1);
      check({tag, "_busy"}, 32'(busy_a), 32'd0);
      check({tag, "_rvalid"}, 32'(rsp_valid_a), 32'd0);
      check({tag, "_sout"}, 32'(serial_out_a), 32'd0);
      check({tag, "_sr_s"}, 32'(sr_s_a), 32'd0);
      check({tag, "_sr_in"}, 32'(sr_in_a), 32'd0);
      check({tag, "_sr_q"}, 32'(sr_q_a), 32'd0);
   endtask

   // Async reset pulsed between clock edges while dut_a is mid-shift
   task automatic reset_mid();
      sel           = 0;
      loop_en       = 1'b1;
      cmd_valid     = 1'b1;
      cmd_data      = 4'b1110;
      cmd_msb_first = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_values("mid_rst");
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("after_rst_rvalid", 32'(rsp_valid_a), 32'd0);
         check("after_rst_busy", 32'(busy_a), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int a_at, cpb;
      rst_n = 1'b0;
      sel = 0; loop_en = 1'b1; si_val = 1'b0;
      cmd_data = '0; cmd_msb_first = 1'b0;
      idle_inputs();
      #12 check_reset_values("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      xfer(0, 4'b1011, 1'b0, 0, -1, 0);
      xfer(0, 4'b1100, 1'b1, 1, -1, 0);
      xfer(0, 4'b0000, 1'b0, 2, -1, 5);
      xfer(0, 4'b0110, 1'b0, 0, 6, 0);
      xfer(0, 4'b1001, 1'b1, 0, -1, 0);
      xfer(0, 4'b0101, 1'b1, 3, 1, 0);
      xfer(0, 4'b0011, 1'b0, 3, 0, 1);
      reset_mid();
      xfer(1, 4'b1011, 1'b0, 0, -1, 0);
      xfer(1, 4'b0111, 1'b1, 3, 3, 0);

      for (int n = 0; n < 60; n++) begin
         cpb  = (n % 2 != 0) ? 1 : 2;
         a_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + 4 * cpb) : -1;
         xfer(n % 2, 4'($urandom), 1'($urandom), ($urandom_range(0, 1) != 0) ? 3 : 0,
              a_at, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
